// File: rtl/ask_pkg.sv
// Shared constants for the ASK deframer: FSM state encoding and the default sync pattern.
package ask_pkg;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

endpackage

// File: rtl/ask_frame_sync.sv
// Deframer behind the ASK demodulator: hunts for the sync word, emits payload bytes
// MSB-first and checks a trailing mod-256 sum checksum.
module ask_frame_sync
  import ask_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       sync_locked,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LAST_BYTE = 4'(PAYLOAD_BYTES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_ok_q, frame_ok_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] shifted;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign shifted = {shreg_q[6:0], bit_in};

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (!en) begin
      // Disable drops the bit in flight and any partial frame.
      state_d    = ST_HUNT;
      shreg_d    = 8'd0;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      csum_d     = 8'd0;
    end else if (bit_valid) begin
      shreg_d = shifted;
      case (state_q)
        ST_HUNT: begin
          if (shifted == SYNC_WORD) begin
            state_d    = ST_PAYLOAD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
            csum_d     = 8'd0;
          end
        end
        ST_PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d   = shifted;
            byte_valid_d = 1'b1;
            csum_d       = csum_q + shifted;
            byte_cnt_d   = byte_cnt_q + 4'd1;
            if (byte_cnt_q == LAST_BYTE) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            frame_done_d = 1'b1;
            frame_ok_d   = (shifted == csum_q);
            if (shifted == csum_q) frame_cnt_d = sat_inc(frame_cnt_q);
            else                   err_cnt_d   = sat_inc(err_cnt_q);
            // Clearing the window keeps checksum bits from forming a false sync.
            state_d   = ST_HUNT;
            shreg_d   = 8'd0;
            bit_cnt_d = 3'd0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          shreg_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      shreg_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 4'd0;
      csum_q       <= 8'd0;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_cnt_q  <= 8'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign sync_locked = (state_q != ST_HUNT);
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
